// File: rtl/ins_decode_seq.sv
// ins_decode_seq
//   Instruction register, fetch/execute phase, sticky halt and carry/zero
//   flags for the simple CPU, plus the one-hot instruction decode that feeds
//   the control-signal generator.
//
// Parameters
//   FLAG_RST    reset value of the carry and zero flags
//   HALT_STICKY 1: halt stays high from the HALT execute cycle until reset
//               0: halt is high only during the HALT execute cycle
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_bus_in    data bus (RAM output), loaded into the IR
//   i_ir_ld     load IR from i_bus_in at the next edge
//   i_sm_en     toggle the fetch/execute phase at the next edge
//   i_cf_en     capture i_alu_cout into the carry flag
//   i_zf_en     capture i_alu_zero into the zero flag
//   i_alu_cout  ALU/shifter carry out
//   i_alu_zero  ALU result-is-zero
//   o_ir        instruction register
//   o_sm        phase: 0 = fetch, 1 = execute
//   o_c, o_z    carry and zero flags
//   o_mova .. o_halt  instruction strobes (one-hot in execute, zero in fetch)
//
// Phase FSM
//   state    | meaning
//   PH_FETCH | fetch cycle, every strobe low
//   PH_EXEC  | execute cycle, exactly one strobe high (decoded from IR)

module ins_decode_seq #(
  parameter logic FLAG_RST    = 1'b0,
  parameter int   HALT_STICKY = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_bus_in,
  input  logic       i_ir_ld,
  input  logic       i_sm_en,
  input  logic       i_cf_en,
  input  logic       i_zf_en,
  input  logic       i_alu_cout,
  input  logic       i_alu_zero,
  output logic [7:0] o_ir,
  output logic       o_sm,
  output logic       o_c,
  output logic       o_z,
  output logic       o_mova,
  output logic       o_movb,
  output logic       o_movc,
  output logic       o_add,
  output logic       o_sub,
  output logic       o_and1,
  output logic       o_not1,
  output logic       o_rsr,
  output logic       o_rsl,
  output logic       o_jmp,
  output logic       o_jz,
  output logic       o_jc,
  output logic       o_in1,
  output logic       o_out1,
  output logic       o_nop,
  output logic       o_halt
);

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_t;

  // Strobe vector bit positions
  localparam int B_MOVA = 15;
  localparam int B_MOVB = 14;
  localparam int B_MOVC = 13;
  localparam int B_ADD  = 12;
  localparam int B_SUB  = 11;
  localparam int B_AND1 = 10;
  localparam int B_NOT1 = 9;
  localparam int B_RSR  = 8;
  localparam int B_RSL  = 7;
  localparam int B_JMP  = 6;
  localparam int B_JZ   = 5;
  localparam int B_JC   = 4;
  localparam int B_IN1  = 3;
  localparam int B_OUT1 = 2;
  localparam int B_NOP  = 1;
  localparam int B_HALT = 0;

  phase_t      r_phase;
  phase_t      w_phase_nxt;
  logic [7:0]  r_ir;
  logic        r_c;
  logic        r_z;
  logic        r_halt_lat;
  logic [15:0] w_dec;
  logic [15:0] w_stb;
  logic        w_halt_set;

  // Phase state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= PH_FETCH;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    if (i_sm_en) begin
      w_phase_nxt = (r_phase == PH_FETCH) ? PH_EXEC : PH_FETCH;
    end
  end

  // IR, flags and halt latch; each update has its own enable
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ir       <= 8'h00;
      r_c        <= FLAG_RST;
      r_z        <= FLAG_RST;
      r_halt_lat <= 1'b0;
    end else begin
      if (i_ir_ld)    r_ir       <= i_bus_in;
      if (i_cf_en)    r_c        <= i_alu_cout;
      if (i_zf_en)    r_z        <= i_alu_zero;
      if (w_halt_set) r_halt_lat <= 1'b1;
    end
  end

  // Raw decode of the IR, only meaningful in execute
  always_comb begin
    w_dec = '0;
    if (r_phase == PH_EXEC) begin
      case (r_ir[7:4])
        4'b1111: begin
          // ir[3:2]==11 wins over ir[1:0]==11, so 8'hFF is movb
          if (r_ir[3:2] == 2'b11)      w_dec[B_MOVB] = 1'b1;
          else if (r_ir[1:0] == 2'b11) w_dec[B_MOVC] = 1'b1;
          else                         w_dec[B_MOVA] = 1'b1;
        end
        4'b1001: w_dec[B_ADD]  = 1'b1;
        4'b0110: w_dec[B_SUB]  = 1'b1;
        4'b1011: w_dec[B_AND1] = 1'b1;
        4'b0101: w_dec[B_NOT1] = 1'b1;
        4'b1010: begin
          case (r_ir[1:0])
            2'b00:   w_dec[B_RSR] = 1'b1;
            2'b11:   w_dec[B_RSL] = 1'b1;
            default: w_dec[B_NOP] = 1'b1;
          endcase
        end
        4'b0011: begin
          case (r_ir[3:0])
            4'b0000: w_dec[B_JMP] = 1'b1;
            4'b0001: w_dec[B_JZ]  = 1'b1;
            4'b0010: w_dec[B_JC]  = 1'b1;
            default: w_dec[B_NOP] = 1'b1;
          endcase
        end
        4'b0010: w_dec[B_IN1]  = 1'b1;
        4'b0100: w_dec[B_OUT1] = 1'b1;
        4'b1000: w_dec[B_HALT] = 1'b1;
        default: w_dec[B_NOP]  = 1'b1;
      endcase
    end
  end

  assign w_halt_set = (HALT_STICKY != 0) && w_dec[B_HALT];

  // A latched halt masks every other strobe regardless of phase and IR
  assign w_stb = r_halt_lat ? 16'(1 << B_HALT) : w_dec;

  assign o_ir   = r_ir;
  assign o_sm   = (r_phase == PH_EXEC);
  assign o_c    = r_c;
  assign o_z    = r_z;
  assign o_mova = w_stb[B_MOVA];
  assign o_movb = w_stb[B_MOVB];
  assign o_movc = w_stb[B_MOVC];
  assign o_add  = w_stb[B_ADD];
  assign o_sub  = w_stb[B_SUB];
  assign o_and1 = w_stb[B_AND1];
  assign o_not1 = w_stb[B_NOT1];
  assign o_rsr  = w_stb[B_RSR];
  assign o_rsl  = w_stb[B_RSL];
  assign o_jmp  = w_stb[B_JMP];
  assign o_jz   = w_stb[B_JZ];
  assign o_jc   = w_stb[B_JC];
  assign o_in1  = w_stb[B_IN1];
  assign o_out1 = w_stb[B_OUT1];
  assign o_nop  = w_stb[B_NOP];
  assign o_halt = w_stb[B_HALT];

endmodule

// File: doc/ins_decode_seq.md
Name: ins_decode_seq

Overview:
- Producer side of the control-signal generator interface in the simple CPU.
- Holds the instruction register (IR), the fetch/execute phase bit `sm`, the sticky halt state, and the carry/zero flag registers.
- Decodes IR into the one-hot instruction strobes (`mova` ... `halt`) plus `z`, `c`, `sm` and `ir` that the control-signal generator consumes.
- Consumes back `ir_ld`, `sm_en`, `cf_en` and `zf_en` from that generator.

Parameters:
- FLAG_RST, 1'b0: reset value of the `c` and `z` flag registers.
- HALT_STICKY, 1: 1 = once HALT executes, `halt` stays high until reset; 0 = `halt` is high only during the HALT execute cycle.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- bus_in  in  8  data bus (RAM output); loaded into IR
- ir_ld  in  1  load IR from bus_in at the next edge
- sm_en  in  1  toggle `sm` at the next edge
- cf_en  in  1  capture alu_cout into `c`
- zf_en  in  1  capture alu_zero into `z`
- alu_cout  in  1  ALU/shifter carry out
- alu_zero  in  1  ALU result-is-zero
- ir  out  8  instruction register
- sm  out  1  phase: 0 = fetch, 1 = execute
- c  out  1  carry flag
- z  out  1  zero flag
- mova, movb, movc, add, sub, and1, not1, rsr, rsl, jmp, jz, jc, in1, out1, nop, halt  out  1 each  instruction strobes

Behaviour:
- Reset (async, immediate):
  - ir=8'h00, sm=0, c=z=FLAG_RST, halt latch=0.
  - All strobes are 0 while rst is high.
- Sequential updates, on the rising edge when not in reset:
  - `ir_ld`=1: ir <= bus_in.
  - `sm_en`=1: sm <= ~sm.
  - `cf_en`=1: c <= alu_cout.
  - `zf_en`=1: z <= alu_zero.
  - All four updates are independent and may occur in the same edge.
- Phase:
  - sm=0 is the fetch cycle; all strobes are 0, including nop.
  - sm=1 is the execute cycle; exactly one strobe is 1, decoded combinationally from ir (zero cycles of latency from the ir/sm registers).
- Decode, sm=1 (op = ir[7:4]):
  - 1111: if ir[3:2]==11 then movb; else if ir[1:0]==11 then movc; else mova. 1111_1111 therefore gives movb.
  - 1001 -> add; 0110 -> sub; 1011 -> and1; 0101 -> not1.
  - 1010: ir[1:0]==00 -> rsr; ir[1:0]==11 -> rsl; otherwise nop.
  - 0011: ir[3:0]==0000 -> jmp; 0001 -> jz; 0010 -> jc; otherwise nop.
  - 0010 -> in1; 0100 -> out1; 1000 -> halt (ir[3:0] ignored).
  - 0000, 0111, 1100, 1101, 1110 -> nop.
- Halt:
  - When the halt strobe is 1 and HALT_STICKY=1, the halt latch is set at that edge.
  - While latched: halt=1 and all other strobes=0, regardless of sm and ir.
  - The downstream `sm_en`=~halt then freezes sm; ir and the flags still honour their own enables.
  - Only rst clears the latch.
- Flags:
  - Jumps (jz, jc) see the flag values registered before the current execute cycle.
  - A flag written in execute cycle N is visible from cycle N+1.
- Invariant: at most one strobe is high in any cycle (one-hot or all-zero).
- Mid-operation reset: returns to fetch (sm=0) with no strobe glitch after rst asserts.

Test Plan:
1. Reset, then sm_en=1, ir_ld=1 pulsed in fetch with bus_in=8'h96 -> after the edge ir=8'h96, sm=1, add=1 only; next edge sm=0 and all strobes are 0.
2. Decode sweep: in execute, ir = F4, FD, F7, FF, 91, 64, B0, 50, A0, A3, A1, 30, 31, 32, 33, 20, 40, 70, 80, 00 -> strobes mova, movb, movc, movb, add, sub, and1, not1, rsr, rsl, nop, jmp, jz, jc, nop, in1, out1, nop, halt, nop respectively; one-hot is checked every cycle.
3. Flags: cf_en=zf_en=1 with alu_cout=1, alu_zero=0 on one edge -> c=1, z=0 the next cycle; cf_en=0 with alu_cout toggling -> c holds 1.
4. Halt (HALT_STICKY=1): execute 8'h80 with the downstream sm_en=~halt -> halt=1 persists over 20 cycles; sm frozen at 1; loading ir=8'h96 leaves add=0; rst clears halt and sm.
5. Async reset mid-execute (sm=1, ir=8'h30): assert rst between edges -> sm=0, ir=0, jmp=0 immediately, without waiting for a clock edge.
6. HALT_STICKY=0: execute 8'h80 -> halt=1 for that cycle only; the following fetch shows halt=0.
